// File: rtl/hwag_tooth_cap.sv
// Crank VR front end: synchronise, glitch-filter, qualify and time the active edge, track teeth.
// Optional HWAG_CAP_EDGE_SEL_EN adds cap_edge to select the rising edge instead of the falling one.
module hwag_tooth_cap #(
  parameter int unsigned PW = 24,
  parameter int unsigned TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_in,
  input  logic [7:0]    filt_len,
  input  logic [PW-1:0] cap_min,
  input  logic [PW-1:0] cap_max,
  input  logic [TW-1:0] tooth_last,
`ifdef HWAG_CAP_EDGE_SEL_EN
  input  logic          cap_edge,
`endif
  output logic          cap_out,
  output logic          cap_stb,
  output logic [PW-1:0] cap_period,
  output logic          gap_stb,
  output logic [TW-1:0] tooth_cnt,
  output logic          sync,
  output logic          err_stb
);

  typedef enum logic [1:0] {StIdle, StMeas, StHunt, StSync} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          cap_out_q, cap_out_d;
  logic          cap_dly_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [PW-1:0] prev_q, prev_d;
  logic          cap_stb_q, cap_stb_d;
  logic [PW-1:0] cap_period_q, cap_period_d;
  logic          gap_stb_q, gap_stb_d;
  logic [TW-1:0] tooth_cnt_q, tooth_cnt_d;
  logic          sync_q, sync_d;
  logic          err_stb_q, err_stb_d;

  logic          act_edge;
  logic          accept;
  logic          timeout;
  logic          is_gap;
  logic [PW:0]   gap_lim;

`ifdef HWAG_CAP_EDGE_SEL_EN
  logic edge_sel_q, edge_sel_d;

  assign act_edge = edge_sel_q ? (cap_out_q & ~cap_dly_q) : (~cap_out_q & cap_dly_q);
`else
  assign act_edge = ~cap_out_q & cap_dly_q;
`endif

  // Gap when the new period exceeds 1.5x the previous one; one extra bit avoids overflow.
  assign gap_lim = {1'b0, prev_q} + {2'b00, prev_q[PW-1:1]};
  assign is_gap  = {1'b0, pcnt_q} > gap_lim;

  // Timeout only matters once an edge has been seen, so it naturally fires once per stall.
  assign timeout = (state_q != StIdle) && (pcnt_q >= cap_max);
  assign accept  = act_edge && (pcnt_q >= cap_min);

  always_comb begin
    fcnt_d       = '0;
    cap_out_d    = cap_out_q;
    pcnt_d       = (pcnt_q == {PW{1'b1}}) ? pcnt_q : pcnt_q + 1'b1;
    prev_d       = prev_q;
    state_d      = state_q;
    cap_stb_d    = 1'b0;
    gap_stb_d    = 1'b0;
    err_stb_d    = 1'b0;
    cap_period_d = cap_period_q;
    tooth_cnt_d  = tooth_cnt_q;
    sync_d       = sync_q;
`ifdef HWAG_CAP_EDGE_SEL_EN
    edge_sel_d   = (state_q == StIdle) ? cap_edge : edge_sel_q;
`endif

    if (sync2_q != cap_out_q) begin
      if (fcnt_q == filt_len) begin
        cap_out_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end

    if (timeout) begin
      err_stb_d   = 1'b1;
      sync_d      = 1'b0;
      tooth_cnt_d = '0;
      state_d     = StIdle;
    end else if (accept) begin
      pcnt_d = {{(PW-1){1'b0}}, 1'b1};
      if (state_q != StIdle) begin
        cap_stb_d    = 1'b1;
        cap_period_d = pcnt_q;
        prev_d       = pcnt_q;
      end
      unique case (state_q)
        StIdle: state_d = StMeas;
        StMeas: state_d = StHunt;
        StHunt: begin
          if (is_gap) begin
            gap_stb_d   = 1'b1;
            tooth_cnt_d = '0;
            sync_d      = 1'b1;
            state_d     = StSync;
          end
        end
        StSync: begin
          if (is_gap) begin
            if (tooth_cnt_q == tooth_last) begin
              tooth_cnt_d = '0;
              gap_stb_d   = 1'b1;
            end else begin
              err_stb_d = 1'b1;
              sync_d    = 1'b0;
              state_d   = StHunt;
            end
          end else begin
            tooth_cnt_d = tooth_cnt_q + 1'b1;
            if (tooth_cnt_q == tooth_last) begin
              err_stb_d = 1'b1;
              sync_d    = 1'b0;
              state_d   = StHunt;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      fcnt_q       <= '0;
      cap_out_q    <= 1'b0;
      cap_dly_q    <= 1'b0;
      pcnt_q       <= '0;
      prev_q       <= '0;
      cap_stb_q    <= 1'b0;
      cap_period_q <= '0;
      gap_stb_q    <= 1'b0;
      tooth_cnt_q  <= '0;
      sync_q       <= 1'b0;
      err_stb_q    <= 1'b0;
`ifdef HWAG_CAP_EDGE_SEL_EN
      edge_sel_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= cap_in;
      sync2_q      <= sync1_q;
      fcnt_q       <= fcnt_d;
      cap_out_q    <= cap_out_d;
      cap_dly_q    <= cap_out_q;
      pcnt_q       <= pcnt_d;
      prev_q       <= prev_d;
      cap_stb_q    <= cap_stb_d;
      cap_period_q <= cap_period_d;
      gap_stb_q    <= gap_stb_d;
      tooth_cnt_q  <= tooth_cnt_d;
      sync_q       <= sync_d;
      err_stb_q    <= err_stb_d;
`ifdef HWAG_CAP_EDGE_SEL_EN
      edge_sel_q   <= edge_sel_d;
`endif
    end
  end

  assign cap_out    = cap_out_q;
  assign cap_stb    = cap_stb_q;
  assign cap_period = cap_period_q;
  assign gap_stb    = gap_stb_q;
  assign tooth_cnt  = tooth_cnt_q;
  assign sync       = sync_q;
  assign err_stb    = err_stb_q;

endmodule

// File: tb/tb_hwag_tooth_cap.sv
// Randomised bench for hwag_tooth_cap: drives VR fall trains and checks strobes against an
// event-level reference model of the capture rules.
module tb_hwag_tooth_cap;
  localparam int PW = 24;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap_in;
  logic [7:0]    filt_len;
  logic [PW-1:0] cap_min;
  logic [PW-1:0] cap_max;
  logic [TW-1:0] tooth_last;
  logic          cap_out;
  logic          cap_stb;
  logic [PW-1:0] cap_period;
  logic          gap_stb;
  logic [TW-1:0] tooth_cnt;
  logic          sync;
  logic          err_stb;
`ifdef HWAG_CAP_EDGE_SEL_EN
  logic          cap_edge = 1'b0;
`endif

  hwag_tooth_cap #(.PW(PW), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_in    (cap_in),
    .filt_len  (filt_len),
    .cap_min   (cap_min),
    .cap_max   (cap_max),
    .tooth_last(tooth_last),
`ifdef HWAG_CAP_EDGE_SEL_EN
    .cap_edge  (cap_edge),
`endif
    .cap_out   (cap_out),
    .cap_stb   (cap_stb),
    .cap_period(cap_period),
    .gap_stb   (gap_stb),
    .tooth_cnt (tooth_cnt),
    .sync      (sync),
    .err_stb   (err_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit stb;
    bit gap;
    bit err;
    int period;
    int tooth;
    bit sync;
  } ev_t;

  ev_t got_q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  always @(negedge clk) begin
    if (!rst && (cap_stb || gap_stb || err_stb)) begin
      mon_e.cyc    = cyc;
      mon_e.stb    = cap_stb;
      mon_e.gap    = gap_stb;
      mon_e.err    = err_stb;
      mon_e.period = int'(cap_period);
      mon_e.tooth  = int'(tooth_cnt);
      mon_e.sync   = sync;
      got_q.push_back(mon_e);
    end
  end

  task automatic do_reset(input int fl, input int cmin, input int cmax, input int tl);
    filt_len   = 8'(fl);
    cap_min    = PW'(cmin);
    cap_max    = PW'(cmax);
    tooth_last = TW'(tl);
    cap_in     = 1'b1;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
  endtask

  // Each iv entry is the distance in clk cycles from the previous fall (or from now).
  task automatic drive(input int iv[$], input int tail, output int tf[$]);
    int since;
    int lw;
    since = 0;
    tf.delete();
    foreach (iv[i]) begin
      repeat (iv[i] - since) begin @(posedge clk); #1; end
      cap_in = 1'b0;
      tf.push_back(cyc);
      lw = int'(filt_len) + 2 + int'($urandom_range(0, 4));
      repeat (lw) begin @(posedge clk); #1; end
      cap_in = 1'b1;
      since = lw;
    end
    repeat (tail) begin @(posedge clk); #1; end
  endtask

  // Reference: walks the fall times and applies the capture rules as plain arithmetic.
  task automatic model(input int tf[$], input int end_cyc, output ev_t ex[$]);
    int  lat, phase, last, prev, tooth, d, cmin, cmax, tl;
    bit  lk, gapf;
    ev_t e;
    lat   = int'(filt_len) + 4;
    cmin  = int'(cap_min);
    cmax  = int'(cap_max);
    tl    = int'(tooth_last);
    phase = 0;  // 0 waiting, 1 first period, 2 hunting, 3 locked
    last  = -1000000;
    prev  = 0;
    tooth = 0;
    lk    = 1'b0;
    ex.delete();
    foreach (tf[i]) begin
      d = tf[i] - last;
      if (phase != 0 && d >= cmax) begin
        e.cyc = last + lat + cmax; e.stb = 0; e.gap = 0; e.err = 1;
        e.period = 0; e.tooth = 0; e.sync = 0;
        ex.push_back(e);
        phase = 0; lk = 0; tooth = 0;
        if (d == cmax) continue;
      end
      if (d < cmin) continue;
      if (phase == 0) begin
        phase = 1;
        last  = tf[i];
        continue;
      end
      e.cyc = tf[i] + lat; e.stb = 1; e.gap = 0; e.err = 0; e.period = d;
      gapf = d > prev + prev / 2;
      if (phase == 1) begin
        phase = 2;
      end else if (phase == 2) begin
        if (gapf) begin e.gap = 1; tooth = 0; lk = 1; phase = 3; end
      end else begin
        if (gapf) begin
          if (tooth == tl) begin tooth = 0; e.gap = 1; end
          else begin e.err = 1; lk = 0; phase = 2; end
        end else begin
          if (tooth == tl) begin e.err = 1; lk = 0; phase = 2; end
          tooth = (tooth + 1) % (1 << TW);
        end
      end
      e.tooth = tooth; e.sync = lk;
      ex.push_back(e);
      prev = d;
      last = tf[i];
    end
    if (phase != 0 && end_cyc >= last + lat + cmax) begin
      e.cyc = last + lat + cmax; e.stb = 0; e.gap = 0; e.err = 1;
      e.period = 0; e.tooth = 0; e.sync = 0;
      ex.push_back(e);
    end
  endtask

  task automatic test_reset();
    do_reset(0, 128, 65535, 57);
    total++;
    if ({cap_out, cap_stb, gap_stb, err_stb, sync, cap_period, tooth_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got out=%0b stb=%0b gap=%0b err=%0b sync=%0b per=%0d tooth=%0d, want all 0",
               cap_out, cap_stb, gap_stb, err_stb, sync, cap_period, tooth_cnt);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cap_out !== 1'b1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL reset_idle_high: got cap_out=%0b events=%0d, want cap_out=1 events=0",
               cap_out, got_q.size());
    end
  endtask

  task automatic test_glitch();
    int t0, t1, lows, fallc, sp;
    do_reset(3, 20, 65535, 57);
    repeat (300) begin @(posedge clk); #1; end
    cap_in = 1'b0;
    t0 = cyc;
    repeat (8) begin @(posedge clk); #1; end
    cap_in = 1'b1;
    repeat (100) begin @(posedge clk); #1; end
    cap_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    cap_in = 1'b1;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (cap_out !== 1'b1) lows++;
    end
    total++;
    if (lows != 0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL glitch_reject: got low_cycles=%0d events=%0d, want 0 and 0", lows, got_q.size());
    end
    sp = int'($urandom_range(150, 250));
    @(posedge clk); #1;
    while (cyc < t0 + sp) begin @(posedge clk); #1; end
    cap_in = 1'b0;
    t1 = cyc;
    fallc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cap_out === 1'b0 && fallc < 0) fallc = cyc;
      if (k == 10) cap_in = 1'b1;
    end
    total++;
    if (fallc != t1 + 6) begin
      bad++;
      $display("FAIL glitch_fall_latency: got cap_out fall at %0d, want %0d", fallc, t1 + 6);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL glitch_event_count: got %0d events, want 1", got_q.size());
    end else begin
      total++;
      if (got_q[0].cyc != t1 + 7 || got_q[0].period != t1 - t0 || got_q[0].stb !== 1'b1) begin
        bad++;
        $display("FAIL glitch_stb: got cyc=%0d per=%0d stb=%0b, want cyc=%0d per=%0d stb=1",
                 got_q[0].cyc, got_q[0].period, got_q[0].stb, t1 + 7, t1 - t0);
      end
    end
  endtask

  task automatic test_period();
    int  iv[$];
    int  tf[$];
    ev_t ex[$];
    int  lat, nz;
    bit  seen;
    do_reset(int'($urandom_range(0, 3)), 128, 65535, 57);
    lat = int'(filt_len) + 4;
    iv.push_back(300);
    repeat (8) iv.push_back(256);
    iv.push_back(50);
    iv.push_back(206);
    repeat (3) iv.push_back(256);
    repeat (16) iv.push_back(int'($urandom_range(60, 600)));
    drive(iv, 100, tf);
    model(tf, cyc, ex);
    total++;
    if (got_q.size() != ex.size()) begin
      bad++;
      $display("FAIL period_count: got %0d events, want %0d", got_q.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].cyc != ex[i].cyc || got_q[i].stb !== ex[i].stb || got_q[i].gap !== ex[i].gap ||
          got_q[i].err !== ex[i].err || got_q[i].sync !== ex[i].sync ||
          (ex[i].stb && got_q[i].period != ex[i].period) ||
          ((ex[i].sync || !ex[i].stb) && got_q[i].tooth != ex[i].tooth)) begin
        bad++;
        $display("FAIL period_ev%0d: got cyc=%0d stb=%0b gap=%0b err=%0b per=%0d tooth=%0d sync=%0b, want cyc=%0d stb=%0b gap=%0b err=%0b per=%0d tooth=%0d sync=%0b",
                 i, got_q[i].cyc, got_q[i].stb, got_q[i].gap, got_q[i].err, got_q[i].period,
                 got_q[i].tooth, got_q[i].sync, ex[i].cyc, ex[i].stb, ex[i].gap, ex[i].err,
                 ex[i].period, ex[i].tooth, ex[i].sync);
      end
    end
    // Direct check of the noise edge, independent of the model.
    nz = -1;
    seen = 1'b0;
    foreach (got_q[i]) begin
      if (got_q[i].cyc == tf[9] + lat) seen = 1'b1;
      if (got_q[i].cyc == tf[10] + lat) nz = got_q[i].period;
    end
    total++;
    if (seen || nz != 256) begin
      bad++;
      $display("FAIL noise_reject: got noise_strobe=%0b next_period=%0d, want 0 and 256", seen, nz);
    end
  endtask

  task automatic test_sync();
    int  iv[$];
    int  tf[$];
    ev_t ex[$];
    int  p;
    do_reset(int'($urandom_range(0, 3)), 60, 65535, 57);
    p = int'($urandom_range(100, 140));
    iv.push_back(300);
    repeat (int'($urandom_range(5, 30))) iv.push_back(p + int'($urandom_range(0, 6)) - 3);
    iv.push_back(3 * p + int'($urandom_range(0, 20)) - 10);
    for (int r = 0; r < 4; r++) begin
      repeat (57) iv.push_back(p + int'($urandom_range(0, 6)) - 3);
      if (r == 2) iv.push_back(p);
      else iv.push_back(3 * p + int'($urandom_range(0, 20)) - 10);
    end
    repeat (5) iv.push_back(p + int'($urandom_range(0, 6)) - 3);
    drive(iv, 100, tf);
    model(tf, cyc, ex);
    total++;
    if (got_q.size() != ex.size()) begin
      bad++;
      $display("FAIL sync_count: got %0d events, want %0d", got_q.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].cyc != ex[i].cyc || got_q[i].stb !== ex[i].stb || got_q[i].gap !== ex[i].gap ||
          got_q[i].err !== ex[i].err || got_q[i].sync !== ex[i].sync ||
          (ex[i].stb && got_q[i].period != ex[i].period) ||
          ((ex[i].sync || !ex[i].stb) && got_q[i].tooth != ex[i].tooth)) begin
        bad++;
        $display("FAIL sync_ev%0d: got cyc=%0d stb=%0b gap=%0b err=%0b per=%0d tooth=%0d sync=%0b, want cyc=%0d stb=%0b gap=%0b err=%0b per=%0d tooth=%0d sync=%0b",
                 i, got_q[i].cyc, got_q[i].stb, got_q[i].gap, got_q[i].err, got_q[i].period,
                 got_q[i].tooth, got_q[i].sync, ex[i].cyc, ex[i].stb, ex[i].gap, ex[i].err,
                 ex[i].period, ex[i].tooth, ex[i].sync);
      end
    end
    total++;
    if (sync !== 1'b1 || tooth_cnt !== TW'(5)) begin
      bad++;
      $display("FAIL sync_final: got sync=%0b tooth=%0d, want sync=1 tooth=5", sync, tooth_cnt);
    end
  endtask

  task automatic test_stall_reset();
    int  iv[$];
    int  tf[$];
    ev_t ex[$];
    int  tl;
    tl = int'($urandom_range(4, 10));
    do_reset(int'($urandom_range(0, 3)), 60, 4096, tl);
    iv.push_back(300);
    repeat (3) iv.push_back(256);
    iv.push_back(768);
    repeat (tl) iv.push_back(256);
    iv.push_back(768);
    repeat (3) iv.push_back(256);
    iv.push_back(5000);
    iv.push_back(256);
    iv.push_back(256);
    drive(iv, 100, tf);
    model(tf, cyc, ex);
    total++;
    if (got_q.size() != ex.size()) begin
      bad++;
      $display("FAIL stall_count: got %0d events, want %0d", got_q.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].cyc != ex[i].cyc || got_q[i].stb !== ex[i].stb || got_q[i].gap !== ex[i].gap ||
          got_q[i].err !== ex[i].err || got_q[i].sync !== ex[i].sync ||
          (ex[i].stb && got_q[i].period != ex[i].period) ||
          ((ex[i].sync || !ex[i].stb) && got_q[i].tooth != ex[i].tooth)) begin
        bad++;
        $display("FAIL stall_ev%0d: got cyc=%0d stb=%0b gap=%0b err=%0b per=%0d tooth=%0d sync=%0b, want cyc=%0d stb=%0b gap=%0b err=%0b per=%0d tooth=%0d sync=%0b",
                 i, got_q[i].cyc, got_q[i].stb, got_q[i].gap, got_q[i].err, got_q[i].period,
                 got_q[i].tooth, got_q[i].sync, ex[i].cyc, ex[i].stb, ex[i].gap, ex[i].err,
                 ex[i].period, ex[i].tooth, ex[i].sync);
      end
    end
    // Asynchronous reset between clock edges must clear outputs without waiting for a clock.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    got_q.delete();
    total++;
    if ({cap_out, cap_stb, gap_stb, err_stb, sync, cap_period, tooth_cnt} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got out=%0b stb=%0b gap=%0b err=%0b sync=%0b per=%0d tooth=%0d, want all 0",
               cap_out, cap_stb, gap_stb, err_stb, sync, cap_period, tooth_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != 0 || cap_period !== '0) begin
      bad++;
      $display("FAIL post_reset_quiet: got events=%0d per=%0d, want 0 and 0", got_q.size(), cap_period);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cap_in     = 1'b1;
    filt_len   = '0;
    cap_min    = '0;
    cap_max    = '0;
    tooth_last = '0;
    test_reset();
    test_glitch();
    test_period();
    test_sync();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
